// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared types and sizing helpers
// for the carry-split pipelined adder.
package pipe_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_mode_e;

  function automatic int slice_w(
    input int width,
    input int stages
  );
    return width / stages;
  endfunction

  function automatic bit split_ok(
    input int width,
    input int stages
  );
    return (stages >= 1) && (stages <= width)
      && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_n_slice.sv
// add_slice: one W-bit carry chain segment, also
// exposing the carry into its MSB for overflow.
module add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cm
);

  logic [W:0] t;

  assign t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  assign s  = t[W-1:0];
  assign co = t[W];
  // MSB sum bit = x ^ y ^ carry-in, so recover the carry
  assign cm = t[W-1] ^ x[W-1] ^ y[W-1];

endmodule

// File: rtl/pipe_adder_n.sv
// pipe_adder_n: WIDTH-bit add/sub resolved SLICE bits
// per stage, global-stall valid/ready pipeline.
module pipe_adder_n
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SL = slice_w(WIDTH, STAGES);

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipe_adder_n: bad WIDTH/STAGES split");
  end

  op_mode_e         mode;
  logic             adv;
  logic             xfer_in;
  logic             c0;
  logic [WIDTH-1:0] b_eff;

  assign mode     = op_mode_e'(sub);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign xfer_in  = in_valid && adv;
  assign b_eff    = (mode == OP_SUB) ? ~b : b;
  assign c0       = (mode == OP_SUB) ? 1'b1 : cin;

  // g_st[k] runs slice k and owns stage k+1 registers
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SL;
    localparam int HI = (k + 1) * SL;
    localparam int UW = WIDTH - LO;

    logic          vin;
    logic          ci;
    logic          co;
    logic          msb_ci;
    logic [UW-1:0] ua_in;
    logic [UW-1:0] ub_in;
    logic [SL-1:0] s_new;
    logic [HI-1:0] s_nxt;
    logic          v_d, v_q;
    logic          c_d, c_q;
    logic [HI-1:0] s_d, s_q;

    if (k == 0) begin : g_head
      assign vin   = xfer_in;
      assign ci    = c0;
      assign ua_in = a;
      assign ub_in = b_eff;
      assign s_nxt = s_new;
    end else begin : g_body
      assign vin   = g_st[k-1].v_q;
      assign ci    = g_st[k-1].c_q;
      assign ua_in = g_st[k-1].g_up.ua_q;
      assign ub_in = g_st[k-1].g_up.ub_q;
      assign s_nxt = {s_new, g_st[k-1].s_q};
    end

    add_slice #(
      .W(SL)
    ) u_slice (
      .x (ua_in[SL-1:0]),
      .y (ub_in[SL-1:0]),
      .ci(ci),
      .s (s_new),
      .co(co),
      .cm(msb_ci)
    );

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (adv) begin
        v_d = vin;
        c_d = co;
        s_d = s_nxt;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_up
      logic [UW-SL-1:0] ua_d, ua_q;
      logic [UW-SL-1:0] ub_d, ub_q;
      logic             unused_msb;

      assign unused_msb = msb_ci;

      always_comb begin
        ua_d = ua_q;
        ub_d = ub_q;
        if (adv) begin
          ua_d = ua_in[UW-1:SL];
          ub_d = ub_in[UW-1:SL];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ua_q <= '0;
          ub_q <= '0;
        end else begin
          ua_q <= ua_d;
          ub_q <= ub_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      always_comb begin
        ovf_d = ovf_q;
        if (adv) ovf_d = msb_ci ^ co;
      end

      always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_adder_n.sv
// tb_pipe_adder_n: directed and random-handshake
// checks for the 32/4 and 8/1 configurations.
module tb_pipe_adder_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        cin8 = 1'b0;
  logic        sub8 = 1'b0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [7:0]  sum8;
  logic        cout8;
  logic        ovf8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_adder_n #(
    .WIDTH (32),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  pipe_adder_n #(
    .WIDTH (8),
    .STAGES(1)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .sub      (sub8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .sum      (sum8),
    .cout     (cout8),
    .ovf      (ovf8)
  );

  function automatic logic [33:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        ci,
    input logic        s
  );
    logic [32:0] t;
    logic        o;
    if (s) begin
      t = {1'b0, x} + {1'b0, ~y} + 33'd1;
      o = (x[31] != y[31]) && (t[31] != x[31]);
    end else begin
      t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
      o = (x[31] == y[31]) && (t[31] != x[31]);
    end
    return {o, t[32], t[31:0]};
  endfunction

  // one beat into an otherwise idle pipe, out_ready high;
  // lat = edges after the accepting edge until out_valid
  task automatic run_one(
    input  logic [31:0] ta,
    input  logic [31:0] tb_v,
    input  logic        tcin,
    input  logic        tsub,
    output int          lat
  );
    a         = ta;
    b         = tb_v;
    cin       = tcin;
    sub       = tsub;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got=%h/%b/%b exp=0/0/0",
               sum, cout, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w8 got v=%b r=%b exp v=0 r=1",
               out_valid8, in_ready8);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    run_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL add_wrap_latency got=%0d exp=3", lat);
    end
    checks++;
    if (sum !== 32'h0) begin
      errors++;
      $display("FAIL add_wrap_sum got=%h exp=00000000", sum);
    end
    checks++;
    if (cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap_flags got c=%b o=%b exp c=1 o=0",
               cout, ovf);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_one(32'h5, 32'h7, 1'b1, 1'b1, lat);
    checks++;
    if (lat !== 3 || sum !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL sub_neg got=%h lat=%0d exp=fffffffe lat=3",
               sum, lat);
    end
    checks++;
    if (cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg_flags got c=%b o=%b exp c=0 o=0",
               cout, ovf);
    end
    run_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 3 || sum !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL sub_min got=%h lat=%0d exp=7fffffff lat=3",
               sum, lat);
    end
    checks++;
    if (cout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_min_flags got c=%b o=%b exp c=1 o=1",
               cout, ovf);
    end
  endtask

  task automatic test_add_ovf();
    int lat;
    run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 3 || sum !== 32'h8000_0000) begin
      errors++;
      $display("FAIL add_ovf got=%h lat=%0d exp=80000000 lat=3",
               sum, lat);
    end
    checks++;
    if (cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf_flags got c=%b o=%b exp c=0 o=1",
               cout, ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] expq[$];
    logic [33:0] exp_v;
    logic [33:0] held;
    logic        stall;
    logic        took;
    int          sent;
    int          rcvd;
    int          cyc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    held  = '0;
    stall = 1'b0;
    took  = 1'b1;
    sent  = 0;
    rcvd  = 0;
    cyc   = 0;
    while (rcvd < 64 && cyc < 2000) begin
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== held) begin
          errors++;
          $display("FAIL b2b_stall_hold got=%b/%h exp=1/%h",
                   out_valid, {ovf, cout, sum}, held);
        end
      end
      if (took) begin
        a   = $urandom();
        b   = $urandom();
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 64);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL b2b_in_ready got=%b exp=%b",
                 in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got=%h exp=none", sum);
        end else begin
          exp_v = expq.pop_front();
          if ({ovf, cout, sum} !== exp_v) begin
            errors++;
            $display("FAIL b2b_result #%0d got=%h exp=%h",
                     rcvd, {ovf, cout, sum}, exp_v);
          end
        end
        rcvd++;
      end
      took = in_valid && in_ready;
      if (took) begin
        expq.push_back(model(a, b, cin, sub));
        sent++;
      end
      stall = out_valid && !out_ready;
      held  = {ovf, cout, sum};
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (rcvd != 64 || sent != 64 || expq.size() != 0) begin
      errors++;
      $display("FAIL b2b_count got rx=%0d tx=%0d left=%0d exp=64/64/0",
               rcvd, sent, expq.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_flush();
    int lat;
    logic seen;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a        = 32'(i);
      b        = 32'(i * 16);
      cin      = 1'b0;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sum !== 32'h0) begin
      errors++;
      $display("FAIL flush_reset got v=%b s=%h exp v=0 s=0",
               out_valid, sum);
    end
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale got=1 exp=0");
    end
    run_one(32'h3, 32'h4, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 3 || sum !== 32'h7) begin
      errors++;
      $display("FAIL flush_next got=%h lat=%0d exp=7 lat=3",
               sum, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_alone got v=%b exp=0", out_valid);
    end
  endtask

  task automatic test_w8();
    a8        = 8'hF0;
    b8        = 8'h20;
    cin8      = 1'b1;
    sub8      = 1'b0;
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    #1;
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_pre got r=%b v=%b exp r=1 v=0",
               in_ready8, out_valid8);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b1 || sum8 !== 8'h11) begin
      errors++;
      $display("FAIL w8_add got v=%b s=%h exp v=1 s=11",
               out_valid8, sum8);
    end
    checks++;
    if (cout8 !== 1'b1 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_flags got c=%b o=%b exp c=1 o=0",
               cout8, ovf8);
    end
    a8        = 8'h7F;
    b8        = 8'h01;
    cin8      = 1'b0;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b1 || sum8 !== 8'h80 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_ovf got v=%b s=%h o=%b exp v=1 s=80 o=1",
               out_valid8, sum8, ovf8);
    end
    a8        = 8'h10;
    b8        = 8'h20;
    cin8      = 1'b1;
    sub8      = 1'b1;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    sub8      = 1'b0;
    checks++;
    if (sum8 !== 8'hF0 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_sub got s=%h c=%b o=%b exp s=f0 c=0 o=0",
               sum8, cout8, ovf8);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("FAIL w8_drain got v=%b exp=0", out_valid8);
    end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub();
    test_add_ovf();
    test_back_to_back();
    test_reset_flush();
    test_w8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
